exec_issue_sched: RTL and testbench
===================================

Name: exec_issue_sched

Overview:
- Issue scheduler between the add/sub and mul/div reservation stations and the single shared execute operand bus.
- Each cycle it picks at most one ready RS entry and grants it.
- It tracks the non-pipelined multiplier's occupancy.
- It keeps a result-bus reservation table so that no two issued ops complete in the same cycle.

Parameters:
N_ADD, 3, add/sub RS entries
N_MUL, 3, mul/div RS entries
IDX_W, 2, entry index width (must satisfy 2^IDX_W >= max(N_ADD,N_MUL))
ADD_LAT, 1, add/sub cycles from issue to writeback (>=1)
MUL_LAT, 4, mul/div cycles from issue to writeback; multiplier is non-pipelined (ADD_LAT < MUL_LAT <= 15)

Ports:
clk1  in  1  single clock, posedge
rst  in  1  asynchronous, active-high reset
add_ready  in  N_ADD  per entry: busy and both operand-available bits set
mul_ready  in  N_MUL  same, for mul RS
flush  in  1  synchronous squash of all scheduler state
add_grant  out  N_ADD  one-hot or zero; the RS captures this entry's operands onto the exec bus this cycle
mul_grant  out  N_MUL  one-hot or zero
exec_valid  out  1  an op is issued this cycle
exec_is_mul  out  1  issued op class; 0 means add
exec_idx  out  IDX_W  index of the granted entry
mul_busy  out  1  multiplier occupied (registered)
wb_valid  out  1  a previously issued op completes this cycle (registered)
wb_is_mul  out  1  class of the completing op

Behaviour:
- Reset, asynchronous:
  - Registers: mul counter=0, reservation table=0, both round-robin pointers=0, tie flag pri_mul=1.
  - Outputs: wb_valid=0, wb_is_mul=0, mul_busy=0.
  - Grants, exec_valid, exec_is_mul and exec_idx are all 0.
- Grants are combinational from the current ready inputs and the registered state (same-cycle issue).
- At most one grant across both vectors per cycle. exec_valid = OR of all grant bits.
- When exec_valid=0, exec_idx=0 and exec_is_mul=0.
- Reservation table resv[MUL_LAT:1]:
  - resv[k]=1 means a writeback is already booked k cycles from now.
  - Every cycle the table shifts down by one. wb_valid/wb_is_mul for the next cycle take the value of resv[1] and its class tag.
- Add class is legal when add_ready is nonzero and the ADD_LAT slot is free after the shift. Same-cycle issue also counts as booking.
- Mul class is legal when mul_ready is nonzero, the mul counter is 0, and the MUL_LAT slot is free.
- Class choice:
  - If only one class is legal, it wins.
  - If both are legal, pri_mul selects the winner and pri_mul then toggles.
  - pri_mul changes only on contested cycles.
- Entry choice within a class: round-robin. Search starts at that class's pointer and wraps at N-1 to 0. Pointer becomes (granted index + 1) mod N; it is updated only on a grant of that class.
- On a grant, the booking takes effect at the clock edge:
  - Add: sets slot ADD_LAT.
  - Mul: sets slot MUL_LAT and loads the mul counter with MUL_LAT-1. The counter decrements to 0; mul_busy = (counter != 0).
- Latency: an op issued in cycle t produces wb_valid=1 in exactly cycle t+ADD_LAT or t+MUL_LAT. Never two completions in one cycle.
- Mul at t with MUL_LAT=4: add with ADD_LAT=1 is blocked at t+3 (slot collision) and legal at t+1, t+2 and t+4.
- Ready inputs may drop without a grant; the scheduler holds no per-entry state. A dropped entry is simply not considered.
- flush=1:
  - No grant in that cycle.
  - Next edge clears the reservation table, mul counter, wb_valid and pri_mul (back to 1).
  - Round-robin pointers are kept.
- rst asserted mid-operation: booked writebacks are discarded; wb_valid=0 immediately.

Test Plan:
- Reset with both classes ready → no grant during reset. First cycle after reset: mul_grant=001, exec_is_mul=1, exec_idx=0, mul_busy=1 next cycle. wb_valid with wb_is_mul=1 exactly 4 cycles after issue.
- add_ready=111 held, mul_ready=0 → add_grant sequence 001,010,100,001. wb_valid asserted every cycle from 1 cycle after the first issue.
- Mul issued at t, add_ready=001 held from t → add granted at t+1 and t+2, no grant at t+3, add granted at t+4. wb pattern: add, add, mul, add, with no double completion.
- mul_ready=010 held continuously → grants at t, t+4 and t+8 only. mul_busy high t+1..t+3.
- Both classes ready and legal on two contested cycles, separated by cycles where mul is blocked → winners are mul then add (pri_mul alternates). Uncontested cycles do not toggle it.
- Mul issued at t, flush at t+2 → no wb_valid at t+4. mul_busy=0 at t+3. Next mul may be granted at t+3.

Source files
------------

// File: rtl/exec_issue_sched.sv
// Issue scheduler: picks one ready add/sub or mul/div RS entry per cycle, tracks the
// non-pipelined multiplier and books result-bus slots so completions never collide.
module exec_issue_sched #(
  parameter int N_ADD   = 3,
  parameter int N_MUL   = 3,
  parameter int IDX_W   = 2,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 4
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic [N_ADD-1:0] add_ready,
  input  logic [N_MUL-1:0] mul_ready,
  input  logic             flush,
  output logic [N_ADD-1:0] add_grant,
  output logic [N_MUL-1:0] mul_grant,
  output logic             exec_valid,
  output logic             exec_is_mul,
  output logic [IDX_W-1:0] exec_idx,
  output logic             mul_busy,
  output logic             wb_valid,
  output logic             wb_is_mul
);

  localparam int MAXN = (N_ADD > N_MUL) ? N_ADD : N_MUL;
  localparam logic [MUL_LAT:1] ADD_SLOT = MUL_LAT'(1) << (ADD_LAT - 1);
  localparam logic [MUL_LAT:1] MUL_SLOT = MUL_LAT'(1) << (MUL_LAT - 1);

  logic [MUL_LAT:1] r_resv;
  logic [MUL_LAT:1] r_resv_mul;
  logic [3:0]       r_mul_cnt;
  logic [IDX_W-1:0] r_add_ptr;
  logic [IDX_W-1:0] r_mul_ptr;
  logic             r_pri_mul;
  logic             r_mul_busy;
  logic             r_wb_valid;
  logic             r_wb_is_mul;

  logic [IDX_W:0]   w_add_pick;
  logic [IDX_W:0]   w_mul_pick;
  logic             w_add_legal;
  logic             w_mul_legal;
  logic             w_sel_mul;
  logic             w_issue_add;
  logic             w_issue_mul;
  logic             w_contest;
  logic [MUL_LAT:1] w_book;
  logic [MUL_LAT:1] w_book_mul;
  logic [3:0]       w_cnt_nxt;
  logic [IDX_W-1:0] w_add_ptr_nxt;
  logic [IDX_W-1:0] w_mul_ptr_nxt;

  // Round-robin search from ptr, wrapping at n-1; returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [MAXN-1:0] ready, input int n,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < MAXN; i++) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      else        j = j;
      if ((i < n) && !found && ready[j]) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Class legality, arbitration and booking of the issued op's writeback slot.
  always_comb begin
    w_add_pick  = rr_pick(MAXN'(add_ready), N_ADD, r_add_ptr);
    w_mul_pick  = rr_pick(MAXN'(mul_ready), N_MUL, r_mul_ptr);
    w_add_legal = 1'b0;
    w_mul_legal = 1'b0;
    w_sel_mul   = 1'b0;
    if (!rst && !flush) begin
      w_add_legal = (|add_ready) && !r_resv[ADD_LAT];
      w_mul_legal = (|mul_ready) && (r_mul_cnt == 4'd0) && !r_resv[MUL_LAT];
    end else begin
      w_add_legal = 1'b0;
      w_mul_legal = 1'b0;
    end
    if (w_add_legal && w_mul_legal) w_sel_mul = r_pri_mul;
    else                            w_sel_mul = w_mul_legal;
    w_contest   = w_add_legal && w_mul_legal;
    w_issue_add = w_add_legal && !w_sel_mul;
    w_issue_mul = w_mul_legal && w_sel_mul;
    w_book      = r_resv | (w_issue_add ? ADD_SLOT : '0) | (w_issue_mul ? MUL_SLOT : '0);
    w_book_mul  = r_resv_mul | (w_issue_mul ? MUL_SLOT : '0);
    if (w_issue_mul)             w_cnt_nxt = 4'(MUL_LAT - 1);
    else if (r_mul_cnt != 4'd0)  w_cnt_nxt = r_mul_cnt - 4'd1;
    else                         w_cnt_nxt = r_mul_cnt;
  end

  // Grant vectors, exec bus descriptor and next round-robin pointers.
  always_comb begin
    add_grant     = '0;
    mul_grant     = '0;
    exec_idx      = '0;
    w_add_ptr_nxt = r_add_ptr;
    w_mul_ptr_nxt = r_mul_ptr;
    if (w_issue_add) begin
      add_grant[w_add_pick[IDX_W-1:0]] = 1'b1;
      exec_idx = w_add_pick[IDX_W-1:0];
      if (w_add_pick[IDX_W-1:0] == IDX_W'(N_ADD - 1)) w_add_ptr_nxt = '0;
      else w_add_ptr_nxt = w_add_pick[IDX_W-1:0] + IDX_W'(1);
    end else if (w_issue_mul) begin
      mul_grant[w_mul_pick[IDX_W-1:0]] = 1'b1;
      exec_idx = w_mul_pick[IDX_W-1:0];
      if (w_mul_pick[IDX_W-1:0] == IDX_W'(N_MUL - 1)) w_mul_ptr_nxt = '0;
      else w_mul_ptr_nxt = w_mul_pick[IDX_W-1:0] + IDX_W'(1);
    end else begin
      exec_idx = '0;
    end
    exec_valid  = w_issue_add || w_issue_mul;
    exec_is_mul = w_issue_mul;
  end

  // Scheduler state; flush squashes bookings but keeps the round-robin pointers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_resv      <= '0;
      r_resv_mul  <= '0;
      r_mul_cnt   <= 4'd0;
      r_mul_busy  <= 1'b0;
      r_add_ptr   <= '0;
      r_mul_ptr   <= '0;
      r_pri_mul   <= 1'b1;
      r_wb_valid  <= 1'b0;
      r_wb_is_mul <= 1'b0;
    end else if (flush) begin
      r_resv      <= '0;
      r_resv_mul  <= '0;
      r_mul_cnt   <= 4'd0;
      r_mul_busy  <= 1'b0;
      r_pri_mul   <= 1'b1;
      r_wb_valid  <= 1'b0;
      r_wb_is_mul <= 1'b0;
    end else begin
      r_resv      <= {1'b0, w_book[MUL_LAT:2]};
      r_resv_mul  <= {1'b0, w_book_mul[MUL_LAT:2]};
      r_wb_valid  <= w_book[1];
      r_wb_is_mul <= w_book_mul[1];
      r_mul_cnt   <= w_cnt_nxt;
      r_mul_busy  <= (w_cnt_nxt != 4'd0);
      r_add_ptr   <= w_add_ptr_nxt;
      r_mul_ptr   <= w_mul_ptr_nxt;
      r_pri_mul   <= w_contest ? !r_pri_mul : r_pri_mul;
    end
  end

  assign mul_busy  = r_mul_busy;
  assign wb_valid  = r_wb_valid;
  assign wb_is_mul = r_wb_is_mul;

endmodule

// File: tb/tb_exec_issue_sched.sv
// Randomized bench for exec_issue_sched against a timeline model of booked completions.
module tb_exec_issue_sched;

  localparam int N_ADD   = 3;
  localparam int N_MUL   = 3;
  localparam int IDX_W   = 2;
  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int NCYC    = 700;

  logic             clk1;
  logic             rst;
  logic [N_ADD-1:0] add_ready;
  logic [N_MUL-1:0] mul_ready;
  logic             flush;
  logic [N_ADD-1:0] add_grant;
  logic [N_MUL-1:0] mul_grant;
  logic             exec_valid;
  logic             exec_is_mul;
  logic [IDX_W-1:0] exec_idx;
  logic             mul_busy;
  logic             wb_valid;
  logic             wb_is_mul;

  int n_checks = 0;
  int n_errors = 0;

  // completion timeline: bk[t]=1 means some op writes back in cycle t
  bit bk     [0:NCYC+16];
  bit bk_mul [0:NCYC+16];
  int ptr_a, ptr_m, mul_last;
  bit pri;

  exec_issue_sched #(.N_ADD(N_ADD), .N_MUL(N_MUL), .IDX_W(IDX_W),
                     .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk1(clk1), .rst(rst), .add_ready(add_ready), .mul_ready(mul_ready), .flush(flush),
    .add_grant(add_grant), .mul_grant(mul_grant), .exec_valid(exec_valid),
    .exec_is_mul(exec_is_mul), .exec_idx(exec_idx), .mul_busy(mul_busy),
    .wb_valid(wb_valid), .wb_is_mul(wb_is_mul)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check_eq(input string tag, input int cyc, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr(input int rdy, input int n, input int p);
    for (int i = 0; i < n; i++) begin
      if (rdy[(p + i) % n]) return (p + i) % n;
    end
    return -1;
  endfunction

  initial begin
    int  e_ag, e_mg, e_ev, e_em, e_ei, e_wb, e_wbm, e_busy, k;
    bit  al, ml, pick_mul;
    rst = 1'b1; flush = 1'b0; add_ready = '0; mul_ready = '0;
    ptr_a = 0; ptr_m = 0; pri = 1'b1; mul_last = -100;
    for (int now = 0; now < NCYC; now++) begin
      @(posedge clk1);
      #1;
      rst   = (now < 3) || (now >= 350 && now < 352);
      flush = !rst && ($urandom_range(0, 24) == 0);
      add_ready = ($urandom_range(0, 9) < 3) ? '0 : N_ADD'($urandom_range(0, 7));
      mul_ready = ($urandom_range(0, 9) < 4) ? '0 : N_MUL'($urandom_range(0, 7));
      if (rst) begin
        add_ready = '1;
        mul_ready = '1;
      end
      #1;
      e_ag = 0; e_mg = 0; e_ev = 0; e_em = 0; e_ei = 0;
      e_wb   = rst ? 0 : int'(bk[now]);
      e_wbm  = rst ? 0 : int'(bk[now] && bk_mul[now]);
      e_busy = rst ? 0 : int'(now > mul_last && now < mul_last + MUL_LAT);
      if (!rst && !flush) begin
        al = (add_ready != 0) && !bk[now + ADD_LAT];
        ml = (mul_ready != 0) && (now >= mul_last + MUL_LAT) && !bk[now + MUL_LAT];
        if (al && ml) begin
          pick_mul = pri;
          pri = !pri;
        end else begin
          pick_mul = ml;
        end
        if (al || ml) begin
          e_ev = 1;
          e_em = int'(pick_mul);
          if (pick_mul) begin
            k = rr(int'(mul_ready), N_MUL, ptr_m);
            e_mg = 1 << k;
            ptr_m = (k + 1) % N_MUL;
            bk[now + MUL_LAT] = 1'b1;
            bk_mul[now + MUL_LAT] = 1'b1;
            mul_last = now;
          end else begin
            k = rr(int'(add_ready), N_ADD, ptr_a);
            e_ag = 1 << k;
            ptr_a = (k + 1) % N_ADD;
            bk[now + ADD_LAT] = 1'b1;
            bk_mul[now + ADD_LAT] = 1'b0;
          end
          e_ei = k;
        end
      end
      check_eq("add_grant", now, 32'(add_grant), 32'(e_ag));
      check_eq("mul_grant", now, 32'(mul_grant), 32'(e_mg));
      check_eq("exec_valid", now, 32'(exec_valid), 32'(e_ev));
      check_eq("exec_is_mul", now, 32'(exec_is_mul), 32'(e_em));
      check_eq("exec_idx", now, 32'(exec_idx), 32'(e_ei));
      check_eq("wb_valid", now, 32'(wb_valid), 32'(e_wb));
      check_eq("wb_is_mul", now, 32'(wb_is_mul), 32'(e_wbm));
      check_eq("mul_busy", now, 32'(mul_busy), 32'(e_busy));
      if (rst) begin
        for (int t = 0; t <= NCYC + 16; t++) begin
          bk[t] = 1'b0;
          bk_mul[t] = 1'b0;
        end
        ptr_a = 0; ptr_m = 0; pri = 1'b1; mul_last = -100;
      end else if (flush) begin
        for (int t = now + 1; t <= now + MUL_LAT + 1; t++) begin
          bk[t] = 1'b0;
          bk_mul[t] = 1'b0;
        end
        pri = 1'b1; mul_last = -100;
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
